chipper_ni: RTL

- Local network interface for one CHIPPER router node. It sits between the processing element (PE) and the router's local port.
- Injection side: buffers PE flits and drives the router `lin` input, holding each flit until the router signals a free injection slot.
- Ejection side: captures flits the router presents on `lout` and queues them to the PE. Ejection can never stall the router (bufferless network), so overflow is dropped and counted.
- Flit format, 10 bits: [9] valid, [8:5] payload, [4:0] destination node id.

---
 rtl/chipper_pkg.sv | 18 +
 rtl/chipper_ni_fifo.sv | 70 +++++++
 rtl/chipper_ni.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/chipper_pkg.sv
// chipper_pkg: shared flit layout constants and injection FSM state type
// for the CHIPPER router local network interface.
//   Flit (10 bits): [9] valid, [8:5] payload, [4:0] destination node id.
package chipper_pkg;

    localparam int unsigned FLIT_W    = 10;
    localparam int unsigned VALID_BIT = 9;
    localparam int unsigned DST_LSB   = 0;
    localparam int unsigned DST_W     = 5;
    localparam int unsigned PAY_LSB   = 5;
    localparam int unsigned PAY_W     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } inj_state_t;

endpackage

// File: rtl/chipper_ni_fifo.sv
// chipper_ni_fifo: synchronous FIFO with first-word fall-through head and
// occupancy count. DEPTH must be a power of two (pointers wrap naturally).
// A write while full is accepted only when a read happens on the same edge.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_wr_en/i_wr_data write request and data
//   i_rd_en           pop request (ignored when empty)
//   o_rd_data         current head entry
//   o_count           registered occupancy, 0..DEPTH
module chipper_ni_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_rd;
    logic w_do_wr;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_rd   = i_rd_en && !w_empty;
    // At full, the slot freed by a same-edge pop is reused (pop-then-push).
    assign w_do_wr   = i_wr_en && (!w_full || w_do_rd);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_wr && w_do_rd) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/chipper_ni.sv
// chipper_ni: local network interface of one CHIPPER router node.
//   Injection: PE flits are buffered and presented on lin until the router
//   signals inj_ready. Ejection: flits on lout are queued to the PE; the
//   router is never stalled, so flits arriving at a full queue are dropped
//   and counted.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pe_tx_data/valid/ready         PE -> NI flit {payload, dst}
//   lin, inj_ready                 NI -> router local input
//   lout                           router -> NI ejected flit
//   pe_rx_data/valid/ready         NI -> PE flit {payload, dst}
//   misroute                       pulse: ejected flit not addressed here
//   drop_cnt                       saturating count of dropped flits
// Optional: define CHIPPER_NI_STATS_EN to add inj_cnt / ej_cnt counters.
module chipper_ni
    import chipper_pkg::*;
#(
    parameter logic [4:0]  NODE_ID   = 5'd0,
    parameter int unsigned INJ_DEPTH = 4,
    parameter int unsigned EJ_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-2:0] pe_tx_data,
    input  logic              pe_tx_valid,
    output logic              pe_tx_ready,
    output logic [FLIT_W-1:0] lin,
    input  logic              inj_ready,
    input  logic [FLIT_W-1:0] lout,
    output logic [FLIT_W-2:0] pe_rx_data,
    output logic              pe_rx_valid,
    input  logic              pe_rx_ready,
    output logic              misroute,
    output logic [7:0]        drop_cnt
`ifdef CHIPPER_NI_STATS_EN
    ,
    output logic [15:0]       inj_cnt,
    output logic [15:0]       ej_cnt
`endif
);

    localparam int unsigned INJ_CW = $clog2(INJ_DEPTH) + 1;
    localparam int unsigned EJ_CW  = $clog2(EJ_DEPTH) + 1;

    // ---------------- injection ----------------
    logic [INJ_CW-1:0] w_inj_count;
    logic [FLIT_W-2:0] w_inj_head;
    logic              w_inj_full;
    logic              w_inj_push;
    logic              w_inj_pop;
    inj_state_t        r_state;
    inj_state_t        w_state_next;

    assign w_inj_full  = (w_inj_count == INJ_CW'(INJ_DEPTH));
    assign pe_tx_ready = !w_inj_full;
    assign w_inj_push  = pe_tx_valid && !w_inj_full;
    assign w_inj_pop   = (r_state == HOLD) && inj_ready;

    chipper_ni_fifo #(
        .WIDTH (FLIT_W - 1),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (w_inj_push),
        .i_wr_data (pe_tx_data),
        .i_rd_en   (w_inj_pop),
        .o_rd_data (w_inj_head),
        .o_count   (w_inj_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HOLD tracks "FIFO non-empty after this edge", so a flit written into
    // an empty FIFO is on lin right after its write edge, and lin is built
    // only from registered state (FSM + FIFO storage).
    always_comb begin
        w_state_next = r_state;
        lin          = '0;
        case (r_state)
            IDLE: begin
                if (w_inj_push) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                lin = {1'b1, w_inj_head};
                if (w_inj_pop && !w_inj_push && (w_inj_count == INJ_CW'(1))) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- ejection ----------------
    logic [EJ_CW-1:0] w_ej_count;
    logic             w_ej_full;
    logic             w_ej_push;
    logic             w_ej_pop;
    logic             w_drop;
    logic             r_misroute;
    logic [7:0]       r_drop_cnt;

    assign w_ej_full   = (w_ej_count == EJ_CW'(EJ_DEPTH));
    assign w_ej_push   = lout[VALID_BIT];
    assign pe_rx_valid = (w_ej_count != '0);
    assign w_ej_pop    = pe_rx_valid && pe_rx_ready;
    assign w_drop      = w_ej_push && w_ej_full && !w_ej_pop;

    chipper_ni_fifo #(
        .WIDTH (FLIT_W - 1),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (w_ej_push),
        .i_wr_data (lout[FLIT_W-2:0]),
        .i_rd_en   (w_ej_pop),
        .o_rd_data (pe_rx_data),
        .o_count   (w_ej_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misroute <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_misroute <= w_ej_push && (lout[DST_LSB +: DST_W] != NODE_ID);
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign misroute = r_misroute;
    assign drop_cnt = r_drop_cnt;

`ifdef CHIPPER_NI_STATS_EN
    logic [15:0] r_inj_cnt;
    logic [15:0] r_ej_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_cnt <= '0;
            r_ej_cnt  <= '0;
        end else begin
            if (w_inj_pop) begin
                r_inj_cnt <= r_inj_cnt + 16'd1;
            end
            if (w_ej_push && !w_drop) begin
                r_ej_cnt <= r_ej_cnt + 16'd1;
            end
        end
    end

    assign inj_cnt = r_inj_cnt;
    assign ej_cnt  = r_ej_cnt;
`endif

endmodule
